dcache_mem_bridge: RTL and testbench
====================================

# dcache_mem_bridge

Data-side memory bridge that consumes the execute-stage AGU's dcache request bus and drives a single-port memory bus. Reads are blocking (one outstanding); writes are posted through a small write buffer so a store completes in the cycle it is presented. It sits directly downstream of the AGU and produces the `{ready, rvalid, rdata}` response bus the AGU consumes.

## Interface
- `WB_DEPTH`, default 2: write-buffer entries; power of two, ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `dcache_wdata_bus`  in  `EXM_DCACHE_WD` (106)  request bus, MSB first: `valid`[105], `op`[104] (0 read, 1 write), `addr`[103:72], `uncached`[71], `awstrb`[70:67], `wdata`[66:35], `cacop_en`[34], `cacop_code`[33:32], `cacop_addr`[31:0].
- `dcache_rdata_bus`  out  `EXM_DCACHE_RD` (34)  response bus, MSB first: `ready`[33], `rvalid`[32], `rdata`[31:0].
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  1 write, 0 read.
- `mem_addr`  out  32  word-aligned address (`addr[31:2]`, 2'b00).
- `mem_wstrb`  out  4  byte strobes; 0 on reads.
- `mem_wdata`  out  32  write data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data returned.
- `mem_rdata`  in  32  read data.

## Operation
- States: `IDLE`, `RD_REQ`, `RD_WAIT`, `RESP`. Write buffer is a FIFO of `{addr, awstrb, wdata}` with head/tail pointers wrapping mod `WB_DEPTH` and a count register `0..WB_DEPTH`.
- `ready` is combinational and forced 0 while `reset` is high. Otherwise:
  - Write (`op=1`, `cacop_en=0`): `ready = !full`.
  - Read (`op=0`, `cacop_en=0`): `ready = (state==IDLE) && empty`.
  - `cacop_en=1`: `ready=1`. The request is a no-op (reserved).
- `ready` is evaluated from `op` whether or not `valid` is high.
- A write is accepted when `valid && op && !cacop_en && ready`:
  - `awstrb != 0`: enqueue the entry.
  - `awstrb == 0`: acknowledge and drop.
  - No bypass when full: a full buffer holds `ready` low even if a pop occurs that cycle.
- A read is accepted when `valid && !op && !cacop_en && ready`: latch `addr`, go to `RD_REQ`.
- `RD_REQ`: drive `mem_req=1`, `mem_we=0`, latched address. On `mem_gnt`, go to `RD_WAIT`.
- `RD_WAIT`: on `mem_rvalid`, register `mem_rdata`, go to `RESP`.
- `RESP`: `rvalid=1` for exactly one cycle with registered `rdata`, then `IDLE`.
- Drain: when `state==IDLE` and the buffer is non-empty, drive the head entry on the memory port (`mem_req=1`, `mem_we=1`). On `mem_gnt`, pop.
  - Drain is blocked while a read is outstanding. Reads are never issued while the buffer is non-empty, so memory ordering holds.
- Enqueue and pop in the same cycle: count unchanged, both pointers advance.
- `mem_*` outputs hold stable until `mem_gnt`.
- `mem_rvalid` outside `RD_WAIT` is ignored.
- `uncached` is ignored; every access goes to memory.

## Timing
- Reset: state `IDLE`, count 0, pointers 0, `mem_req=0`, `rvalid=0`, `rdata=0`, `ready=0` during reset.
- Read, best case, with `mem_gnt` immediate and `mem_rvalid` the cycle after grant:
  - accept at T;
  - `mem_req` at T+1;
  - `RD_WAIT` at T+2, data captured;
  - `rvalid` at T+3.
- Response latency: 3 cycles plus memory stalls.
- Write: `ready` in the presentation cycle T; entry visible at T+1; `mem_req` at T+1. Pop at T+2 if granted at T+1.
- `rvalid` is registered; `ready` is combinational.
- Reset mid-read: the transaction is abandoned and no `rvalid` is issued. A late `mem_rvalid` is ignored.
- Reset with a non-empty buffer: buffered writes are discarded.

## Test plan
- Write to 0x100, `awstrb`=4'b0011, data 0x0000BEEF, `mem_gnt` tied 1 -> `ready`=1 at T; `mem_req`/`mem_we`=1, addr 0x100, strb 0011 at T+1; buffer empty at T+2.
- Three back-to-back writes with `mem_gnt`=0 (`WB_DEPTH`=2) -> first two accepted, third sees `ready`=0. Raise `mem_gnt` -> third accepted the cycle after the first pop; memory sees writes in order.
- Write 0x200 then read 0x200 with `mem_gnt` delayed 4 cycles -> read `ready` stays 0 until the buffer drains; read `mem_req` only after the write is granted.
- Read 0x304, `mem_gnt` at T+1, `mem_rvalid` with 0xCAFEF00D at T+2 -> `rvalid`=1, `rdata`=0xCAFEF00D at T+3 only; `mem_addr`=0x304.
- Reset asserted during `RD_WAIT`, then `mem_rvalid` pulses -> no `rvalid`. Next read completes normally.
- Write with `awstrb`=0, and a request with `cacop_en`=1 -> `ready`=1 for both; no `mem_req` issued.

Source files
------------

// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge: AGU dcache request bus to single-port memory bridge with blocking reads and a posted write buffer
// Ports: clk, reset (sync, active-high); dcache_wdata_bus in (106b request), dcache_rdata_bus out ({ready, rvalid, rdata});
//        memory side mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata out, mem_gnt/mem_rvalid/mem_rdata in.
module dcache_mem_bridge #(
    parameter int WB_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [105:0] dcache_wdata_bus,
    output logic [33:0]  dcache_rdata_bus,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [3:0]   mem_wstrb,
    output logic [31:0]  mem_wdata,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RESP} state_t;
    state_t        state;
    logic [29:0]   wb_addr [WB_DEPTH];
    logic [3:0]    wb_strb [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [29:0]   rd_addr;
    logic [31:0]   rdata;
    logic          req_valid, req_op, cacop_en;
    logic [29:0]   req_addr;
    logic [3:0]    req_strb;
    logic [31:0]   req_wdata;
    logic          empty, full, ready, wr_acc, rd_acc, enq, drain, pop, unused;
    assign req_valid = dcache_wdata_bus[105];
    assign req_op    = dcache_wdata_bus[104];
    assign req_addr  = dcache_wdata_bus[103:74];
    assign req_strb  = dcache_wdata_bus[70:67];
    assign req_wdata = dcache_wdata_bus[66:35];
    assign cacop_en  = dcache_wdata_bus[34];
    assign unused    = ^{dcache_wdata_bus[73:71], dcache_wdata_bus[33:0]};
    assign empty  = count == '0;
    assign full   = count == CW'(WB_DEPTH);
    // ready follows op even without valid; a full buffer stays not-ready even on a pop cycle
    assign ready  = !reset && (cacop_en || (req_op ? !full : (state == IDLE && empty)));
    assign wr_acc = req_valid && req_op && !cacop_en && ready;
    assign enq    = wr_acc && req_strb != 4'b0;
    assign rd_acc = req_valid && !req_op && !cacop_en && ready;
    // drain only from IDLE so buffered writes never overtake or interleave with a read
    assign drain  = state == IDLE && !empty;
    assign pop    = drain && mem_gnt && !reset;
    assign mem_req   = !reset && (drain || state == RD_REQ);
    assign mem_we    = drain;
    assign mem_addr  = {drain ? wb_addr[head] : rd_addr, 2'b00};
    assign mem_wstrb = drain ? wb_strb[head] : 4'b0;
    assign mem_wdata = wb_data[head];
    assign dcache_rdata_bus = {ready, state == RESP && !reset, rdata};
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rd_addr <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE:    if (rd_acc) begin
                             state   <= RD_REQ;
                             rd_addr <= req_addr;
                         end
                RD_REQ:  if (mem_gnt) state <= RD_WAIT;
                RD_WAIT: if (mem_rvalid) begin
                             state <= RESP;
                             rdata <= mem_rdata;
                         end
                default: state <= IDLE;
            endcase
            if (enq) begin
                wb_addr[tail] <= req_addr;
                wb_strb[tail] <= req_strb;
                wb_data[tail] <= req_wdata;
                tail          <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// tb_dcache_mem_bridge: randomized and directed checking of dcache_mem_bridge against a queue-based reference model
module tb_dcache_mem_bridge;
    localparam int DEPTH = 2;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [105:0] wbus = '0;
    logic [33:0]  rbus;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_wdata;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    always #5 clk = ~clk;
    dcache_mem_bridge #(.WB_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .dcache_wdata_bus(wbus), .dcache_rdata_bus(rbus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );
    typedef struct {logic [31:0] addr; logic [3:0] strb; logic [31:0] data;} wr_t;
    wr_t         wq[$];
    logic [31:0] ref_mem [256];
    logic [31:0] stub_mem [256];
    bit          rd_active, rd_granted, rd_done;
    logic [31:0] rd_addr;
    bit          stub_wait, force_rv;
    int          stub_delay, max_delay;
    logic [31:0] stub_addr;
    int          n_vec, n_err;
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) old[b*8 +: 8] = d[b*8 +: 8];
        return old;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input bit r, input bit v, input bit o, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit c, input bit g);
        bit          exp_ready, exp_req, rd_gnt;
        logic [31:0] gaddr;
        @(negedge clk);
        reset   = r;
        mem_gnt = g;
        wbus    = {v, o, a, 1'($urandom), s, d, c, 2'($urandom), 32'($urandom)};
        if (stub_wait && !r) begin
            mem_rvalid = stub_delay == 0;
            mem_rdata  = mem_rvalid ? stub_mem[stub_addr[9:2]] : 32'($urandom);
        end else begin
            mem_rvalid = force_rv || $urandom_range(7) == 0;
            mem_rdata  = 32'($urandom);
        end
        #1;
        exp_ready = !r && (c || (o ? wq.size() < DEPTH : (!rd_active && wq.size() == 0)));
        exp_req   = !r && (rd_active ? !rd_granted : wq.size() > 0);
        check("ready", 32'(rbus[33]), 32'(exp_ready));
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req && rd_active) begin
            check("rd_we", 32'(mem_we), 32'd0);
            check("rd_addr", mem_addr, {rd_addr[31:2], 2'b00});
            check("rd_strb", 32'(mem_wstrb), 32'd0);
        end
        if (exp_req && !rd_active) begin
            check("wr_we", 32'(mem_we), 32'd1);
            check("wr_addr", mem_addr, {wq[0].addr[31:2], 2'b00});
            check("wr_strb", 32'(mem_wstrb), 32'(wq[0].strb));
            check("wr_data", mem_wdata, wq[0].data);
        end
        check("rvalid", 32'(rbus[32]), 32'(!r && rd_done));
        if (!r && rd_done) check("rdata", rbus[31:0], ref_mem[rd_addr[9:2]]);
        rd_gnt = !r && mem_req && mem_gnt && !mem_we;
        gaddr  = mem_addr;
        if (!r && mem_req && mem_gnt && mem_we)
            stub_mem[mem_addr[9:2]] = merge(stub_mem[mem_addr[9:2]], mem_wdata, mem_wstrb);
        @(posedge clk);
        if (r) stub_wait = 0;
        else if (stub_wait) begin
            if (mem_rvalid) stub_wait = 0;
            else stub_delay--;
        end else if (rd_gnt) begin
            stub_wait  = 1;
            stub_addr  = gaddr;
            stub_delay = $urandom_range(max_delay);
        end
        if (r) begin
            wq.delete();
            rd_active  = 0;
            rd_granted = 0;
            rd_done    = 0;
        end else begin
            if (rd_done) begin
                rd_active  = 0;
                rd_granted = 0;
                rd_done    = 0;
            end else if (rd_granted) begin
                if (mem_rvalid) rd_done = 1;
            end else if (rd_active) begin
                if (g) rd_granted = 1;
            end else if (wq.size() > 0 && g) begin
                ref_mem[wq[0].addr[9:2]] = merge(ref_mem[wq[0].addr[9:2]], wq[0].data, wq[0].strb);
                void'(wq.pop_front());
            end
            if (v && !c && exp_ready) begin
                if (o) begin
                    if (s != 4'b0) wq.push_back('{a, s, d});
                end else begin
                    rd_active = 1;
                    rd_addr   = a;
                end
            end
        end
    endtask
    task automatic idle(input bit g);
        step(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, g);
    endtask
    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = '0;
            stub_mem[i] = '0;
        end
        max_delay = 0;
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0);
        step(1, 1, 1, 32'h100, 4'hF, 32'h1234, 0, 1);
        #1;
        check("rst_rdata", rbus[31:0], 32'd0);
        check("rst_rvalid", 32'(rbus[32]), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        step(0, 1, 1, 32'h100, 4'b0011, 32'h0000BEEF, 0, 1);
        idle(1);
        idle(1);
        step(0, 1, 1, 32'h104, 4'hF, 32'h11111111, 0, 0);
        step(0, 1, 1, 32'h108, 4'hF, 32'h22222222, 0, 0);
        step(0, 1, 1, 32'h10C, 4'hF, 32'h33333333, 0, 0);
        step(0, 1, 1, 32'h10C, 4'hF, 32'h33333333, 0, 1);
        step(0, 1, 1, 32'h10C, 4'hF, 32'h33333333, 0, 1);
        repeat (4) idle(1);
        step(0, 1, 1, 32'h200, 4'hF, 32'h5A5A5A5A, 0, 0);
        repeat (4) step(0, 1, 0, 32'h200, 4'h0, 32'h0, 0, 0);
        repeat (2) step(0, 1, 0, 32'h200, 4'h0, 32'h0, 0, 1);
        repeat (4) idle(1);
        step(0, 1, 1, 32'h304, 4'hF, 32'hCAFEF00D, 0, 1);
        repeat (2) idle(1);
        step(0, 1, 0, 32'h304, 4'h0, 32'h0, 0, 0);
        repeat (4) idle(1);
        step(0, 1, 0, 32'h100, 4'h0, 32'h0, 0, 0);
        idle(1);
        force_rv = 1;
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0);
        idle(0);
        idle(0);
        force_rv = 0;
        step(0, 1, 0, 32'h108, 4'h0, 32'h0, 0, 0);
        repeat (4) idle(1);
        step(0, 1, 1, 32'h110, 4'h0, 32'hDEADDEAD, 0, 1);
        step(0, 1, 0, 32'h114, 4'hF, 32'h0, 1, 1);
        step(0, 1, 1, 32'h118, 4'hF, 32'h0, 1, 1);
        idle(1);
        max_delay = 3;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(199) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
                 32'(32'h100 + ($urandom_range(15) << 2) + $urandom_range(3)), 4'($urandom),
                 32'($urandom), $urandom_range(15) == 0, $urandom_range(9) < 6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
